mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  N-port memory arbiter. Merges NUM_PORTS requesters, each using the cpu-style
//  handshake (read/write/byte_enable/address/wdata, resp/rdata), onto one
//  physical memory port. Typical use: split I-side/D-side cpu fetch plus a DMA
//  port in front of the shared cache. Only one transaction is in flight at a time.
// PARAMETERS
//  NUM_PORTS  2   requester count, 1..8
//  ADDR_W     32  address width
//  DATA_W     32  data width; byte-enable width BE_W = DATA_W/8
// PORTS
//  clk              in   1                 clock; every flop is rising-edge
//  rst              in   1                 synchronous, active-high reset
//  req_read         in   NUM_PORTS         per-port read request
//  req_write        in   NUM_PORTS         per-port write request
//  req_byte_enable  in   NUM_PORTS*BE_W    port p at [p*BE_W +: BE_W]
//  req_address      in   NUM_PORTS*ADDR_W  port p at [p*ADDR_W +: ADDR_W]
//  req_wdata        in   NUM_PORTS*DATA_W  port p at [p*DATA_W +: DATA_W]
//  req_resp         out  NUM_PORTS         one-hot completion pulse for the owning port
//  req_rdata        out  DATA_W            read data, broadcast; valid with req_resp
//  mem_read         out  1                 to memory/cache
//  mem_write        out  1
//  mem_byte_enable  out  BE_W
//  mem_address      out  ADDR_W
//  mem_wdata        out  DATA_W
//  mem_resp         in   1                 completion from memory
//  mem_rdata        in   DATA_W
// BEHAVIOUR
//  - FSM states: IDLE, BUSY. Reset -> IDLE. Reset clears mem_read, mem_write,
//    mem_byte_enable, mem_address, mem_wdata, req_resp and grant to 0. The
//    round-robin pointer resets to NUM_PORTS-1, so port 0 wins first.
//  - IDLE: port p is requesting when (req_read[p] | req_write[p]). If any port
//    is requesting, the arbiter picks a winner g and, on the same edge, latches
//    g's read, write, byte_enable, address and wdata into the mem_* output
//    registers, then goes to BUSY. With no requesters it stays in IDLE and all
//    mem_* strobes stay at 0.
//  - Latency: mem_read or mem_write rises 1 cycle after the request is first
//    seen in IDLE. mem_* outputs are registered and hold stable through BUSY;
//    later changes on req_* do not affect them.
//  - BUSY: wait for mem_resp. In the mem_resp cycle, combinationally,
//    req_resp[g] = 1 and req_rdata = mem_rdata. On that edge: mem_read and
//    mem_write -> 0, state -> IDLE, pointer <- g.
//  - Result: back-to-back transactions always have at least 1 IDLE cycle.
//  - Requester contract: hold the request until req_resp; deassert it, or
//    present a new request, in the next cycle.
//  - mem_resp seen in IDLE is ignored. Every req_resp bit stays 0 in that case.
//  - req_rdata equals mem_rdata at all times. It is meaningful only while
//    req_resp is asserted.
//  - Read and write asserted together on one port is illegal, covered by an SVA
//    assertion. If it happens, write wins: mem_write=1, mem_read=0.
//  - rst asserted while in BUSY: next edge -> IDLE with all outputs cleared.
//    The aborted transaction gets no req_resp.
//  - NUM_PORTS=1 degenerates to a 1-cycle registered pass-through with no
//    arbitration.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined:
//    winner = first requesting port scanning (pointer+1) mod NUM_PORTS upward,
//    wrapping. This guarantees starvation freedom: wait <= NUM_PORTS-1 grants.
//  MEM_ARB_ROUND_ROBIN_EN undefined:
//    fixed priority, lowest index wins. The pointer register is not built.
// TESTING
//  1 Reset: hold rst 3 cycles while req_read=2'b11 -> all mem_*=0, req_resp=0,
//    state IDLE.
//  2 Single read: port1 reads addr 0x0000_0040. Expect mem_read and
//    mem_address=0x40 the next cycle. mem_resp arrives 4 cycles later with
//    rdata 0xDEAD_BEEF -> req_resp=2'b10, req_rdata=0xDEAD_BEEF in that cycle.
//  3 Write: port0 writes 0x1234_5678 with be=4'b0011 to addr 0x80 ->
//    mem_write=1, mem_wdata=0x1234_5678, mem_byte_enable=4'b0011, all stable
//    until mem_resp. Then req_resp=2'b01.
//  4 Contention, NUM_PORTS=3, both ports 0 and 2 requesting continuously:
//    RR_EN grants 0,2,0,2. Without RR_EN, grants 0,0,0 and port 2 is starved.
//  5 Stray/abort: pulse mem_resp in IDLE -> no req_resp. Assert rst 2 cycles
//    into BUSY -> IDLE, no req_resp. The next request still gets served.
//  6 Stability: change port0 address while BUSY -> mem_address keeps the
//    latched value until resp.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : N-port arbiter that merges cpu-style requesters onto a single
//               memory port, one transaction in flight. Optional macro
//               MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed
//               lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int BE_W     = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*BE_W-1:0]   req_byte_enable,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_resp,
    output logic [DATA_W-1:0]           req_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [BE_W-1:0]             mem_byte_enable,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_resp,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [IDX_W-1:0]     r_grant;
    logic [IDX_W-1:0]     w_winner;
    logic [NUM_PORTS-1:0] w_req;
    logic                 w_any_req;

    logic [BE_W-1:0]      w_be    [NUM_PORTS];
    logic [ADDR_W-1:0]    w_addr  [NUM_PORTS];
    logic [DATA_W-1:0]    w_wdata [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign w_be[p]    = req_byte_enable[p*BE_W +: BE_W];
        assign w_addr[p]  = req_address[p*ADDR_W +: ADDR_W];
        assign w_wdata[p] = req_wdata[p*DATA_W +: DATA_W];
    end

    assign w_req     = req_read | req_write;
    assign w_any_req = |w_req;
    assign req_rdata = mem_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr;

    // Lowest requester overall, overridden by the lowest requester above the
    // pointer: equivalent to scanning upward from pointer+1 with wrap.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_req[i]) w_winner = IDX_W'(i);
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_req[i] && (i > int'(r_ptr))) w_winner = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IDX_W'(NUM_PORTS - 1);
        end else if (r_state == S_BUSY && mem_resp) begin
            r_ptr <= r_grant;
        end
    end
`else
    always_comb begin
        w_winner = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_req[i]) w_winner = IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_BUSY;
            S_BUSY:  if (mem_resp)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant         <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_address     <= '0;
            mem_wdata       <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_any_req) begin
                r_grant         <= w_winner;
                // Illegal read+write on one port resolves to a write.
                mem_write       <= req_write[w_winner];
                mem_read        <= req_read[w_winner] & ~req_write[w_winner];
                mem_byte_enable <= w_be[w_winner];
                mem_address     <= w_addr[w_winner];
                mem_wdata       <= w_wdata[w_winner];
            end
        end else if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    // Completion is suppressed under reset so an aborted transaction never responds.
    always_comb begin
        req_resp = '0;
        if (r_state == S_BUSY && mem_resp && !rst) req_resp[r_grant] = 1'b1;
    end

    a_no_read_and_write : assert property (@(posedge clk) disable iff (rst)
        (req_read & req_write) == '0);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter: cycle table on a 2-port
//               instance plus a contention sequence on a 3-port instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    // 2-port instance
    logic [1:0]  read2, write2, resp2;
    logic [7:0]  be2;
    logic [63:0] addr2, wdata2;
    logic [31:0] rdata2, maddr2, mwdata2, mrdata2;
    logic        mread2, mwrite2, mresp2;
    logic [3:0]  mbe2;

    // 3-port instance
    logic [2:0]  read3, write3, resp3;
    logic [11:0] be3;
    logic [95:0] addr3, wdata3;
    logic [31:0] rdata3, maddr3, mwdata3, mrdata3;
    logic        mread3, mwrite3, mresp3;
    logic [3:0]  mbe3;

    int n_chk;
    int n_fail;

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_read(read2), .req_write(write2), .req_byte_enable(be2),
        .req_address(addr2), .req_wdata(wdata2),
        .req_resp(resp2), .req_rdata(rdata2),
        .mem_read(mread2), .mem_write(mwrite2), .mem_byte_enable(mbe2),
        .mem_address(maddr2), .mem_wdata(mwdata2),
        .mem_resp(mresp2), .mem_rdata(mrdata2)
    );

    mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) dut3 (
        .clk(clk), .rst(rst),
        .req_read(read3), .req_write(write3), .req_byte_enable(be3),
        .req_address(addr3), .req_wdata(wdata3),
        .req_resp(resp3), .req_rdata(rdata3),
        .mem_read(mread3), .mem_write(mwrite3), .mem_byte_enable(mbe3),
        .mem_address(maddr3), .mem_wdata(mwdata3),
        .mem_resp(mresp3), .mem_rdata(mrdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic        mresp;
        logic [31:0] mrdata;
        logic        chk;
        logic        e_rd;
        logic        e_wr;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [1:0]  e_resp;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input int step,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        //           rst   rd     wr     a0        a1        be0   wd0           mresp mrdata       chk   e_rd  e_wr  e_be  e_addr    e_wd          e_resp
        tbl[0]  = '{1'b1, 2'b11, 2'b00, 32'h0,    32'h40,   4'h0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        2'b00};
        tbl[1]  = '{1'b1, 2'b11, 2'b00, 32'h0,    32'h40,   4'h0, 32'h0,        1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        2'b00};
        tbl[2]  = '{1'b1, 2'b11, 2'b00, 32'h0,    32'h40,   4'h0, 32'h0,        1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        2'b00};
        tbl[3]  = '{1'b0, 2'b10, 2'b00, 32'h0,    32'h40,   4'h0, 32'h0,        1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        2'b00};
        tbl[4]  = '{1'b0, 2'b10, 2'b00, 32'h0,    32'h40,   4'h0, 32'h0,        1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 4'hF, 32'h40,   32'hAAAA5555, 2'b00};
        tbl[5]  = '{1'b0, 2'b10, 2'b00, 32'h0,    32'h40,   4'h0, 32'h0,        1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 4'hF, 32'h40,   32'hAAAA5555, 2'b00};
        tbl[6]  = '{1'b0, 2'b10, 2'b00, 32'h0,    32'h40,   4'h0, 32'h0,        1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 4'hF, 32'h40,   32'hAAAA5555, 2'b00};
        tbl[7]  = '{1'b0, 2'b10, 2'b00, 32'h0,    32'h40,   4'h0, 32'h0,        1'b1, 32'hDEADBEEF,1'b1, 1'b1, 1'b0, 4'hF, 32'h40,   32'hAAAA5555, 2'b10};
        tbl[8]  = '{1'b0, 2'b00, 2'b00, 32'h0,    32'h40,   4'h0, 32'h0,        1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 4'hF, 32'h40,   32'hAAAA5555, 2'b00};
        tbl[9]  = '{1'b0, 2'b00, 2'b01, 32'h80,   32'h40,   4'h3, 32'h12345678, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 4'hF, 32'h40,   32'hAAAA5555, 2'b00};
        tbl[10] = '{1'b0, 2'b00, 2'b01, 32'h100,  32'h40,   4'h3, 32'hFFFF0000, 1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 4'h3, 32'h80,   32'h12345678, 2'b00};
        tbl[11] = '{1'b0, 2'b00, 2'b01, 32'h200,  32'h40,   4'h3, 32'hFFFF0000, 1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 4'h3, 32'h80,   32'h12345678, 2'b00};
        tbl[12] = '{1'b0, 2'b00, 2'b01, 32'h200,  32'h40,   4'h3, 32'hFFFF0000, 1'b1, 32'h0BADF00D,1'b1, 1'b0, 1'b1, 4'h3, 32'h80,   32'h12345678, 2'b01};
        tbl[13] = '{1'b0, 2'b00, 2'b00, 32'h200,  32'h40,   4'h3, 32'hFFFF0000, 1'b1, 32'h11111111,1'b1, 1'b0, 1'b0, 4'h3, 32'h80,   32'h12345678, 2'b00};
        tbl[14] = '{1'b0, 2'b01, 2'b00, 32'h300,  32'h40,   4'hC, 32'h5,        1'b1, 32'h22222222,1'b1, 1'b0, 1'b0, 4'h3, 32'h80,   32'h12345678, 2'b00};
        tbl[15] = '{1'b0, 2'b01, 2'b00, 32'h300,  32'h40,   4'hC, 32'h5,        1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 4'hC, 32'h300,  32'h5,        2'b00};
        tbl[16] = '{1'b1, 2'b01, 2'b00, 32'h300,  32'h40,   4'hC, 32'h5,        1'b1, 32'h33333333,1'b1, 1'b1, 1'b0, 4'hC, 32'h300,  32'h5,        2'b00};
        tbl[17] = '{1'b0, 2'b01, 2'b00, 32'h300,  32'h40,   4'hC, 32'h5,        1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        2'b00};
        tbl[18] = '{1'b0, 2'b01, 2'b00, 32'h300,  32'h40,   4'hC, 32'h5,        1'b1, 32'h44444444,1'b1, 1'b1, 1'b0, 4'hC, 32'h300,  32'h5,        2'b01};
        tbl[19] = '{1'b0, 2'b00, 2'b00, 32'h300,  32'h40,   4'hC, 32'h5,        1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 4'hC, 32'h300,  32'h5,        2'b00};

        read3   = '0;
        write3  = '0;
        be3     = '0;
        addr3   = {32'h3000, 32'h2000, 32'h1000};
        wdata3  = '0;
        mresp3  = 1'b0;
        mrdata3 = 32'hC0FFEE00;

        for (int i = 0; i < 20; i++) begin
            rst     = tbl[i].rst;
            read2   = tbl[i].rd;
            write2  = tbl[i].wr;
            addr2   = {tbl[i].a1, tbl[i].a0};
            be2     = {4'hF, tbl[i].be0};
            wdata2  = {32'hAAAA5555, tbl[i].wd0};
            mresp2  = tbl[i].mresp;
            mrdata2 = tbl[i].mrdata;
            #1;
            if (tbl[i].chk) begin
                check("mem_read",  i, 32'(mread2),  32'(tbl[i].e_rd));
                check("mem_write", i, 32'(mwrite2), 32'(tbl[i].e_wr));
                check("mem_be",    i, 32'(mbe2),    32'(tbl[i].e_be));
                check("mem_addr",  i, maddr2,       tbl[i].e_addr);
                check("mem_wdata", i, mwdata2,      tbl[i].e_wd);
                check("req_resp",  i, 32'(resp2),   32'(tbl[i].e_resp));
                check("req_rdata", i, rdata2,       tbl[i].mrdata);
            end
            @(posedge clk);
            #1;
        end

        // Ports 0 and 2 request continuously on the 3-port instance.
        read2  = '0;
        write2 = '0;
        mresp2 = 1'b0;
        read3  = 3'b101;
        for (int n = 0; n < 4; n++) begin
            int exp_port;
            bit seen;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_port = (n % 2 == 0) ? 0 : 2;
`else
            exp_port = 0;
`endif
            seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                if (mread3) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                n_chk++;
                n_fail++;
                $display("FAIL contention grant %0d: got no mem_read expected mem_read within 10 cycles", n);
                break;
            end
            check("contention_addr", n, maddr3, 32'h1000 * (exp_port + 1));
            mresp3 = 1'b1;
            #1;
            check("contention_resp", n, 32'(resp3), 32'(1) << exp_port);
            check("contention_rdata", n, rdata3, 32'hC0FFEE00);
            @(posedge clk);
            #1;
            mresp3 = 1'b0;
        end
        read3 = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
